// File: rtl/cpu_core_params.sv
// Core-wide constants shared by the pipeline front end: datapath width,
// fetch granularity, prefetch depth and the default boot address.
package cpu_core_params;

  localparam int unsigned CORE_XLEN            = 32;
  localparam int unsigned FETCH_BYTES          = 4;
  localparam int unsigned FETCH_FIFO_DEPTH     = 4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding {pc, instruction} pairs between memory and decode.
// Storage is a plain register array; the head reads back as zero when empty.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset_N,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_pop;

  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign do_pop    = pop && !empty;
  assign head_data = empty ? '0 : mem[rd_ptr_reg];

  // Flush wins over any push or pop landing in the same cycle.
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push && !flush) mem[wr_ptr_reg] <= push_data;
  end

  always @(posedge i_Clock) begin
    if (i_Reset_N && !flush)
      assert (!(push && !do_pop && count_reg == CW'(DEPTH)))
        else $error("fetch_fifo: push into full buffer");
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Front-end fetch: issues word reads ahead of decode, bounded by buffer credit,
// and discards in-flight responses that belong to a path abandoned by a redirect.
module instruction_fetch_unit
  import cpu_core_params::*;
#(
  parameter int unsigned     XLEN         = CORE_XLEN,
  parameter int unsigned     FIFO_DEPTH   = FETCH_FIFO_DEPTH,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            i_Clock,
  input  logic            i_Reset_N,
  input  logic            i_Redirect_Valid,
  input  logic [XLEN-1:0] i_Redirect_Addr,
  output logic            o_Mem_Req_Valid,
  input  logic            i_Mem_Req_Ready,
  output logic [XLEN-1:0] o_Mem_Req_Addr,
  input  logic            i_Mem_Rsp_Valid,
  input  logic [XLEN-1:0] i_Mem_Rsp_Data,
  output logic            o_Instr_Valid,
  input  logic            i_Instr_Ready,
  output logic [XLEN-1:0] o_Instruction,
  output logic [XLEN-1:0] o_Instruction_Addr
);

  localparam int unsigned     CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned     SW          = CW + 1;
  localparam logic [SW-1:0]   DEPTH_LIMIT = SW'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP     = XLEN'(FETCH_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(FETCH_BYTES - 1);

  logic [XLEN-1:0]   fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0]   return_pc_reg, return_pc_next;
  logic [CW-1:0]     outstanding_reg, outstanding_next;
  logic [CW-1:0]     discard_reg, discard_next;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [2*XLEN-1:0] fifo_head;
  logic [SW-1:0]     credit_used;
  logic [XLEN-1:0]   redirect_pc;
  logic              req_accept;
  logic              rsp_keep;

  assign redirect_pc = i_Redirect_Addr & ALIGN_MASK;

  // Credit counts both buffered entries and reads still in flight (discarded
  // ones included), so a returning response always finds a free slot.
  assign credit_used     = {1'b0, fifo_count} + {1'b0, outstanding_reg};
  assign o_Mem_Req_Valid = i_Reset_N && !i_Redirect_Valid && (credit_used < DEPTH_LIMIT);
  assign o_Mem_Req_Addr  = fetch_pc_reg;
  assign req_accept      = o_Mem_Req_Valid && i_Mem_Req_Ready;
  assign rsp_keep        = i_Mem_Rsp_Valid && (discard_reg == '0) && !i_Redirect_Valid;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    return_pc_next   = return_pc_reg;
    discard_next     = discard_reg;
    outstanding_next = outstanding_reg + CW'(req_accept) - CW'(i_Mem_Rsp_Valid);
    if (i_Redirect_Valid) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc_next  = redirect_pc;
      return_pc_next = redirect_pc;
      discard_next   = outstanding_reg - CW'(i_Mem_Rsp_Valid);
    end else begin
      if (req_accept) fetch_pc_next = fetch_pc_reg + PC_STEP;
      if (i_Mem_Rsp_Valid && discard_reg != '0) discard_next = discard_reg - CW'(1);
      if (rsp_keep) return_pc_next = return_pc_reg + PC_STEP;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      fetch_pc_reg    <= RESET_VECTOR;
      return_pc_reg   <= RESET_VECTOR;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      return_pc_reg   <= return_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  always @(posedge i_Clock) begin
    if (i_Reset_N)
      assert (!(i_Mem_Rsp_Valid && outstanding_reg == '0))
        else $error("instruction_fetch_unit: response with no request outstanding");
  end

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .i_Clock   (i_Clock),
    .i_Reset_N (i_Reset_N),
    .flush     (i_Redirect_Valid),
    .push      (rsp_keep),
    .push_data ({return_pc_reg, i_Mem_Rsp_Data}),
    .pop       (i_Instr_Ready),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign o_Instr_Valid      = !fifo_empty;
  assign o_Instruction_Addr = fifo_head[2*XLEN-1:XLEN];
  assign o_Instruction      = fifo_head[XLEN-1:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench: an in-order memory model with variable latency feeds the
// fetch unit; a scoreboard of expected {pc, word} pairs is checked at decode.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_addr;

  instruction_fetch_unit dut (
    .i_Clock            (clk),
    .i_Reset_N          (rst_n),
    .i_Redirect_Valid   (redirect_valid),
    .i_Redirect_Addr    (redirect_addr),
    .o_Mem_Req_Valid    (mem_req_valid),
    .i_Mem_Req_Ready    (mem_req_ready),
    .o_Mem_Req_Addr     (mem_req_addr),
    .i_Mem_Rsp_Valid    (mem_rsp_valid),
    .i_Mem_Rsp_Data     (mem_rsp_data),
    .o_Instr_Valid      (instr_valid),
    .i_Instr_Ready      (instr_ready),
    .o_Instruction      (instr),
    .o_Instruction_Addr (instr_addr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  pend_t       pend_q[$];
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1, lat_max = 1;
  int          req_ready_pct = 100, instr_ready_pct = 100, redirect_permil = 0;
  int          accept_cnt = 0, pop_cnt = 0;
  logic [31:0] model_pc = 32'h0;
  logic [31:0] last_accept_addr = '0, last_pop_pc = '0;
  logic        prev_stall = 1'b0, prev_redirect = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endfunction

  // One clock of stimulus: inputs change at the falling edge, outputs are
  // sampled 1 time unit later and describe what the next rising edge sees.
  task automatic step(input bit do_redirect, input logic [31:0] raddr);
    int lat;
    int due;
    @(negedge clk);
    cyc++;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
    mem_req_ready  = ($urandom_range(99) < req_ready_pct);
    instr_ready    = ($urandom_range(99) < instr_ready_pct);
    redirect_valid = do_redirect || (redirect_permil != 0 && $urandom_range(999) < redirect_permil);
    redirect_addr  = do_redirect ? raddr : $urandom;
    #1;
    if (prev_stall && !redirect_valid) begin
      check("req_hold_valid", mem_req_valid, 1'b1);
      check("req_hold_addr", mem_req_addr, prev_addr);
    end
    if (redirect_valid) check("no_req_in_redirect", mem_req_valid, 1'b0);
    if (prev_redirect) check("flushed_after_redirect", instr_valid, 1'b0);
    if (mem_req_valid && mem_req_ready) begin
      check("req_addr", mem_req_addr, model_pc);
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_q.push_back('{mem_req_addr, due});
      exp_q.push_back('{model_pc, mem_word(model_pc)});
      model_pc += 32'd4;
      accept_cnt++;
      last_accept_addr = mem_req_addr;
    end
    prev_stall    = mem_req_valid && !mem_req_ready;
    prev_addr     = mem_req_addr;
    prev_redirect = redirect_valid;
    if (redirect_valid) begin
      exp_q.delete();
      model_pc = {redirect_addr[31:2], 2'b00};
    end
  endtask

  // Decode-side monitor: every instruction consumed must match the scoreboard.
  always @(negedge clk) begin
    #2;
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_instr: got pc 0x%0h, required no instruction", instr_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("instr_pc", instr_addr, mon_e.pc);
        check("instr_data", instr, mon_e.data);
      end
      pop_cnt++;
      last_pop_pc = instr_addr;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    mem_rsp_valid  = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    mem_req_ready  = 1'b0;
    #1;
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_addr", instr_addr, 32'h0);
    pend_q.delete();
    exp_q.delete();
    model_pc      = 32'h0;
    last_due      = 0;
    prev_stall    = 1'b0;
    prev_redirect = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_pop(input logic [31:0] exp_pc, input string name);
    int p0 = pop_cnt;
    int n = 0;
    while (pop_cnt == p0 && n < 50) begin
      step(1'b0, 32'h0);
      #2;
      n++;
    end
    if (pop_cnt == p0) begin
      checks++;
      $display("FAIL %s: no instruction within 50 cycles, required pc 0x%0h", name, exp_pc);
    end else begin
      check(name, last_pop_pc, exp_pc);
    end
  endtask

  task automatic set_knobs(input int lmin, input int lmax, input int rq, input int ir, input int rd);
    lat_min = lmin; lat_max = lmax;
    req_ready_pct = rq; instr_ready_pct = ir; redirect_permil = rd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    int gaps;
    int n;

    // Streaming: 1-cycle memory, decode always ready.
    set_knobs(1, 1, 100, 100, 0);
    do_reset();
    a0 = accept_cnt;
    step(1'b0, 32'h0);
    check("first_req_count", accept_cnt - a0, 1);
    check("first_req_addr", last_accept_addr, 32'h0);
    step(1'b0, 32'h0);
    check("second_req_addr", last_accept_addr, 32'h4);
    step(1'b0, 32'h0);
    check("third_req_addr", last_accept_addr, 32'h8);
    gaps = 0;
    repeat (10) begin
      step(1'b0, 32'h0);
      if (!instr_valid) gaps++;
    end
    check("stream_gaps", gaps, 0);

    // Redirect lands together with a response and a pop.
    step(1'b1, 32'h0000_0203);
    wait_pop(32'h200, "redirect_resp_pop_first_pc");

    // Decode stalled: credit caps issue at FIFO_DEPTH.
    set_knobs(3, 3, 100, 0, 0);
    do_reset();
    a0 = accept_cnt;
    repeat (20) step(1'b0, 32'h0);
    check("credit_limit_reqs", accept_cnt - a0, 4);
    check("credit_req_low", mem_req_valid, 1'b0);
    instr_ready_pct = 100;
    a0 = accept_cnt;
    n = 0;
    while (accept_cnt == a0 && n < 10) begin
      step(1'b0, 32'h0);
      n++;
    end
    check("resume_addr", last_accept_addr, 32'h10);

    // Redirect with reads in flight.
    set_knobs(4, 4, 100, 100, 0);
    do_reset();
    repeat (4) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0103);
    a0 = accept_cnt;
    step(1'b0, 32'h0);
    check("redirect_next_req_count", accept_cnt - a0, 1);
    check("redirect_next_req_addr", last_accept_addr, 32'h100);
    wait_pop(32'h100, "redirect_first_pc");

    // Memory back-pressure for 5 cycles.
    set_knobs(1, 1, 0, 100, 0);
    do_reset();
    a0 = accept_cnt;
    repeat (5) begin
      step(1'b0, 32'h0);
      check("stall_addr", mem_req_addr, 32'h0);
    end
    req_ready_pct = 100;
    step(1'b0, 32'h0);
    check("stall_accept_once", accept_cnt - a0, 1);
    check("stall_accept_addr", last_accept_addr, 32'h0);

    // Reset with reads in flight and entries buffered.
    set_knobs(3, 3, 100, 0, 0);
    do_reset();
    repeat (5) step(1'b0, 32'h0);
    check("prereset_buffered", instr_valid, 1'b1);
    do_reset();
    set_knobs(1, 3, 100, 100, 0);
    a0 = accept_cnt;
    step(1'b0, 32'h0);
    check("postreset_req_addr", last_accept_addr, 32'h0);
    check("postreset_req_count", accept_cnt - a0, 1);

    // Randomized traffic with occasional redirects.
    set_knobs(1, 6, 70, 60, 20);
    repeat (3000) step(1'b0, 32'h0);

    // Drain: stop issuing and let every expected instruction reach decode.
    set_knobs(1, 1, 0, 100, 0);
    n = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 200) begin
      step(1'b0, 32'h0);
      #2;
      n++;
    end
    check("drain_scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the address and instruction width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning prefetch buffer entries; it is a power of two and at least 2.
REQ-003 The block SHALL have parameter RESET_VECTOR, default 0, meaning the first fetch address.
REQ-004 The block SHALL have one clock, i_Clock, and an asynchronous active-low reset, i_Reset_N; the polarity and synchronicity are fixed.
REQ-005 i_Clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 i_Reset_N  in  1  asynchronous, active-low reset.
REQ-007 i_Redirect_Valid  in  1  branch/jump taken; flush and refetch.
REQ-008 i_Redirect_Addr  in  XLEN  new fetch target.
REQ-009 o_Mem_Req_Valid  out  1  instruction memory read request.
REQ-010 i_Mem_Req_Ready  in  1  memory accepts the request.
REQ-011 o_Mem_Req_Addr  out  XLEN  word-aligned request address.
REQ-012 i_Mem_Rsp_Valid  in  1  read data returned, in order, any latency of at least 1 cycle, never back-pressured.
REQ-013 i_Mem_Rsp_Data  in  XLEN  returned instruction word.
REQ-014 o_Instr_Valid  out  1  buffer head holds a valid instruction.
REQ-015 i_Instr_Ready  in  1  decode consumes the head.
REQ-016 o_Instruction  out  XLEN  head instruction.
REQ-017 o_Instruction_Addr  out  XLEN  PC of the head instruction.

Function
REQ-018 The block SHALL keep a fetch PC, an outstanding counter (requests accepted, responses not yet returned) and a discard counter; both counters are clog2(FIFO_DEPTH)+1 bits wide.
REQ-019 o_Mem_Req_Valid SHALL equal (fifo_count + outstanding < FIFO_DEPTH) and not i_Redirect_Valid.
REQ-020 o_Mem_Req_Addr SHALL equal the fetch PC.
REQ-021 When a request is accepted (valid and ready), the fetch PC SHALL advance by 4 (modulo 2^XLEN) and the outstanding counter SHALL increment.
REQ-022 Once asserted, o_Mem_Req_Valid and o_Mem_Req_Addr SHALL hold stable until accepted; the only exception is a redirect, which may withdraw the request.
REQ-023 On i_Mem_Rsp_Valid the outstanding counter SHALL decrement.
REQ-024 On i_Mem_Rsp_Valid with discard count > 0, the data SHALL be dropped and the discard count decremented.
REQ-025 On i_Mem_Rsp_Valid with discard count = 0, the pair {response PC, data} SHALL be pushed; response PCs are tracked by a return-PC register.
REQ-026 A pushed entry SHALL appear on o_Instr_Valid the following cycle; the FIFO is registered.
REQ-027 On o_Instr_Valid and i_Instr_Ready the head SHALL pop.
REQ-028 Push and pop in the same cycle SHALL leave fifo_count unchanged.
REQ-029 The credit rule SHALL guarantee a push never meets a full FIFO.
REQ-030 On redirect the FIFO SHALL be flushed, even if a push or pop coincides.
REQ-031 On redirect the fetch PC and return PC SHALL load {i_Redirect_Addr[XLEN-1:2], 2'b00}.
REQ-032 On redirect the discard count SHALL be set to outstanding minus (i_Mem_Rsp_Valid ? 1 : 0), with all in-flight responses, including one arriving that cycle, dropped.
REQ-033 No request SHALL issue in the redirect cycle; the first request to the new target issues the next cycle.
REQ-034 Back-to-back redirects SHALL each apply; the last one wins, and the discard count is recomputed from the live outstanding count.
REQ-035 o_Instr_Valid SHALL never expose an instruction fetched before the latest redirect.
REQ-036 An error SHALL be flagged in simulation if i_Mem_Rsp_Valid arrives while outstanding = 0 (protocol violation).

Reset
REQ-037 On i_Reset_N low, asynchronously: fetch PC and return PC = RESET_VECTOR; outstanding, discard and fifo_count = 0; o_Mem_Req_Valid = 0; o_Instr_Valid = 0.
REQ-038 On i_Reset_N low, asynchronously: o_Instruction and o_Instruction_Addr = 0.
REQ-039 Reset asserted mid-operation SHALL abandon all in-flight requests; the memory system is reset alongside.
REQ-040 The first request SHALL assert in the first clock edge's cycle after i_Reset_N rises, at address RESET_VECTOR.

Structure
REQ-041 RESET_VECTOR default and the fetch width constants SHALL live in the shared cpu_core_params header with the other core constants.
REQ-042 The buffer SHALL be one sub-module, fetch_fifo: parametrised width 2*XLEN, depth FIFO_DEPTH, with synchronous flush, push/pop, count and empty outputs, and the same reset.
REQ-043 The counters, credit logic and PC registers SHALL remain in instruction_fetch_unit.

Verification
REQ-044 Reset release, memory always ready, 1-cycle latency, decode always ready -> requests 0x0, 0x4, 0x8 on consecutive cycles; o_Instruction_Addr sequence 0x0, 0x4, 0x8 with no gaps after fill.
REQ-045 Decode ready held low, FIFO_DEPTH=4, latency 3 -> exactly 4 requests issued, then o_Mem_Req_Valid low; raising ready resumes fetch at 0x10.
REQ-046 Two requests outstanding (0x8, 0xC), redirect to 0x103 -> both responses dropped, FIFO empty, next request 0x100, first delivered instruction PC 0x100.
REQ-047 Redirect in the same cycle as response and pop -> that response dropped, FIFO empty next cycle, discard count = outstanding-1.
REQ-048 i_Mem_Req_Ready low for 5 cycles -> o_Mem_Req_Addr stable at 0x0 throughout; accepted exactly once.
REQ-049 Reset asserted with 3 outstanding and 2 buffered -> all outputs zero immediately; first post-reset request at RESET_VECTOR.
